// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: synchronised RX deserialiser and TX serialiser, bit time = max(divider, 4) clocks.
// Define UART_RX_FRAME_ERR_EN to add rx_frame_err and drop bytes whose stop bit samples as 0.
module uart_transceiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] divider,
  input  logic [7:0]  data_tx,
  input  logic        have_data_tx,
  output logic        transmitting,
  output logic [7:0]  data_rx,
  output logic        have_data_rx,
  input  logic        data_rx_ack,
  input  logic        rx,
`ifdef UART_RX_FRAME_ERR_EN
  output logic        rx_frame_err,
`endif
  output logic        tx
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [11:0] div_eff;
  assign div_eff = (divider < 12'd4) ? 12'd4 : divider;

  logic [SYNC_N-1:0] sync_q;
  logic              rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_N-1];

  // ---------------------------------------------------------------- TX
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [11:0] tx_div_q, tx_div_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_shift_d   = tx_shift_q;
    tx_div_d     = tx_div_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    transmitting = 1'b0;
    tx           = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (have_data_tx) begin
          tx_state_d = TX_SHIFT;
          tx_shift_d = {1'b1, data_tx, 1'b0};
          tx_div_d   = div_eff;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_SHIFT: begin
        transmitting = 1'b1;
        tx           = tx_shift_q[0];
        if (tx_cnt_q == tx_div_q - 12'd1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_div_q, rx_div_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  data_rx_q, data_rx_d;
  logic        have_q, have_d;
  logic        rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic        rx_stop_q, rx_stop_d;
  logic        rx_wait_q, rx_wait_d;
  logic        ferr_q, ferr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      data_rx_q  <= '0;
      have_q     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_stop_q  <= 1'b1;
      rx_wait_q  <= 1'b0;
      ferr_q     <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_rx_q  <= data_rx_d;
      have_q     <= have_d;
`ifdef UART_RX_FRAME_ERR_EN
      rx_stop_q  <= rx_stop_d;
      rx_wait_q  <= rx_wait_d;
      ferr_q     <= ferr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    data_rx_d  = data_rx_q;
    have_d     = have_q;
    rx_done    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    rx_stop_d  = rx_stop_q;
    rx_wait_d  = rx_wait_q;
    ferr_d     = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
`ifdef UART_RX_FRAME_ERR_EN
        // After a framing error the line must go idle before a new start bit counts.
        if (rx_wait_q) begin
          if (rx_s) rx_wait_d = 1'b0;
        end else
`endif
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_div_d   = div_eff;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 12'd1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - 12'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_STOP: begin
        // Stop mid-point at count D-1; the byte is handed over one edge later at count D.
        if (rx_cnt_q == rx_div_q) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_stop_q) begin
            rx_done = 1'b1;
          end else begin
            ferr_d    = 1'b1;
            rx_wait_d = 1'b1;
          end
`else
          rx_done = 1'b1;
`endif
        end else begin
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_cnt_q == rx_div_q - 12'd1) rx_stop_d = rx_s;
`endif
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A completing byte beats a same-cycle ack.
    if (rx_done) begin
      data_rx_d = rx_shift_q;
      have_d    = 1'b1;
    end else if (data_rx_ack) begin
      have_d    = 1'b0;
    end
  end

  assign data_rx      = data_rx_q;
  assign have_data_rx = have_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign rx_frame_err = ferr_q;
`endif

endmodule
